// File: rtl/ci_pkg.sv
// Shared definitions for the CI frame streamer: frame-size defaults,
// FSM state encoding and the address-width helper.
package ci_pkg;

  // Default frame geometry
  localparam int CI_COLS   = 30;
  localparam int CI_ROWS   = 30;
  localparam int CI_DATA_W = 8;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREFETCH = 2'd1;
  localparam logic [1:0] ST_STREAM   = 2'd2;
  localparam logic [1:0] ST_WAIT_RES = 2'd3;

  // Address width for an n-entry array, never narrower than one bit
  function automatic int ci_addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ci_frame_streamer_if.sv
// Bus bundle between the frame streamer and its driver: frame-buffer write
// port, start request, CI result-done input and the pixel stream outputs.
interface ci_frame_streamer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              start_i;
  logic              ci_done_i;
  logic [DATA_W-1:0] grayscale_o;
  logic              done_o;
  logic              busy_o;
  logic              frame_done_o;
  logic              timeout_o;

  // Side that loads the frame and watches the stream
  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, start_i, ci_done_i,
    input  grayscale_o, done_o, busy_o, frame_done_o, timeout_o
  );

  // Streamer side
  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, start_i, ci_done_i,
    output grayscale_o, done_o, busy_o, frame_done_o, timeout_o
  );
endinterface

// File: rtl/ci_frame_ram.sv
// Frame buffer: one write port, one registered read port, no reset on the
// storage or read register so it maps onto block RAM.
module ci_frame_ram
  import ci_pkg::*;
#(
  parameter int DEPTH  = CI_COLS * CI_ROWS,
  parameter int DATA_W = CI_DATA_W,
  parameter int ADDR_W = ci_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Synchronous write and synchronous read; caller keeps both addresses in range
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ci_frame_streamer.sv
// Streams a stored ROWS x COLS frame to CI_top in raster order, one pixel per
// cycle, then waits for the CI result-done or a timeout before going idle.
module ci_frame_streamer
  import ci_pkg::*;
#(
  parameter int COLS    = CI_COLS,
  parameter int ROWS    = CI_ROWS,
  parameter int DATA_W  = CI_DATA_W,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  ci_frame_streamer_if.slave  bus
);

  localparam int NPIX   = ROWS * COLS;
  localparam int ADDR_W = ci_addr_w(NPIX);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int TO_W   = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] NPIX_C  = CNT_W'(NPIX);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [DATA_W-1:0] gray_q, gray_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              fdone_q, fdone_d;
  logic              tout_q, tout_d;

  logic              wr_ok;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Frame writes only land while idle and inside the frame
  assign wr_ok = bus.wr_en_i && (state_q == ST_IDLE) && ({1'b0, bus.wr_addr_i} < NPIX_C);

  // Read addr 0 during PREFETCH, then run one pixel ahead of the output register
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state_q == ST_PREFETCH) begin
      rd_en = 1'b1;
    end else if (state_q == ST_STREAM && cnt_inc < NPIX_C) begin
      rd_en   = 1'b1;
      rd_addr = cnt_inc[ADDR_W-1:0];
    end
  end

  ci_frame_ram #(
    .DEPTH (NPIX),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_ok),
    .waddr_i(bus.wr_addr_i),
    .wdata_i(bus.wr_data_i),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  // Next-state logic: pixel/done outputs and result pulses default low every cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    gray_d  = '0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    fdone_d = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_PREFETCH;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_PREFETCH: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // One extra cycle after the last pixel drops done_o before WAIT_RES
        if (cnt_q == NPIX_C) begin
          state_d = ST_WAIT_RES;
          to_d    = '0;
        end else begin
          gray_d = rd_data;
          done_d = 1'b1;
          cnt_d  = cnt_inc;
        end
      end
      ST_WAIT_RES: begin
        // Result-done takes priority over a simultaneous expiry
        if (bus.ci_done_i) begin
          fdone_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          to_d    = '0;
        end else if (to_q == TO_LAST) begin
          tout_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          to_d    = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      gray_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      gray_q  <= gray_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.grayscale_o  = gray_q;
  assign bus.done_o       = done_q;
  assign bus.busy_o       = busy_q;
  assign bus.frame_done_o = fdone_q;
  assign bus.timeout_o    = tout_q;

endmodule

// File: tb/tb_ci_frame_streamer.sv
// Self-checking bench for ci_frame_streamer: a frame model in an array,
// table-driven start/result scenarios, hand sequences for busy-time writes
// and mid-stream reset, and randomized frames.
module tb_ci_frame_streamer;

  localparam int COLS    = 30;
  localparam int ROWS    = 30;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int NPIX    = ROWS * COLS;
  localparam int ADDR_W  = 10;

  logic clk;
  logic rst;

  ci_frame_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ci_frame_streamer #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference frame contents as the bench believes them to be
  int model_mem [NPIX];

  typedef struct {
    string name;
    bit    wr_with_start;
    int    wa;
    int    wd;
    int    ci_delay;   // cycles after done_o falls before ci_done_i rises; -1 = never
    bit    stale;      // ci_done_i already high throughout the stream
    int    exp_first;  // expected first streamed pixel
    bit    exp_fdone;  // 1 = frame_done_o pulse, 0 = timeout_o pulse
    int    exp_cyc;    // cycles from done_o falling to the pulse
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "/gray"},  32'(bus.grayscale_o), 32'(0));
    check({name, "/done"},  32'(bus.done_o), 32'(0));
    check({name, "/busy"},  32'(bus.busy_o), 32'(0));
    check({name, "/fdone"}, 32'(bus.frame_done_o), 32'(0));
    check({name, "/tout"},  32'(bus.timeout_o), 32'(0));
  endtask

  task automatic write_px(input int addr, input int data);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = ADDR_W'(addr);
    bus.wr_data_i = DATA_W'(data);
    cyc();
    bus.wr_en_i = 1'b0;
    if (addr < NPIX) model_mem[addr] = data % 256;
  endtask

  // Expected response time: ci_done seen at the edge ci_delay+1 after done_o
  // falls, unless the TIMEOUT-cycle wait runs out first
  function automatic int model_latency(input int ci_delay);
    return (ci_delay >= 0 && ci_delay < TIMEOUT) ? ci_delay + 1 : TIMEOUT;
  endfunction

  task automatic run_frame(input string tag, input bit wr_with_start, input int wa, input int wd,
                           input int ci_delay, input bit stale, input int inject_at,
                           input int reset_at, output int first_px, output int got_c,
                           output int got_fd);
    int bad, first_bad, early, last_px;
    bit seen;
    first_px = -1;
    got_c    = -1;
    got_fd   = -1;
    if (wr_with_start) begin
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = ADDR_W'(wa);
      bus.wr_data_i = DATA_W'(wd);
      if (wa < NPIX) model_mem[wa] = wd;
    end
    bus.start_i   = 1'b1;
    bus.ci_done_i = stale;
    cyc();
    bus.wr_en_i = 1'b0;
    bus.start_i = 1'b0;
    check({tag, "/busy_after_start"}, 32'(bus.busy_o), 32'(1));
    check({tag, "/done_T1"}, 32'(bus.done_o), 32'(0));
    cyc();
    check({tag, "/done_T2"}, 32'(bus.done_o), 32'(0));
    bad = 0; first_bad = -1; early = 0; last_px = -1;
    for (int k = 0; k < NPIX; k++) begin
      if (k == inject_at) begin
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = '0;
        bus.wr_data_i = 8'hFF;
        bus.start_i   = 1'b1;
      end
      cyc();
      bus.wr_en_i = 1'b0;
      bus.start_i = 1'b0;
      if (k == reset_at) begin
        #2 rst = 1'b0;
        #1;
        check({tag, "/done_async_drop"}, 32'(bus.done_o), 32'(0));
        check_idle_outputs({tag, "/in_reset"});
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs({tag, "/held_reset"});
        rst = 1'b1;
        bus.ci_done_i = 1'b0;
        cyc();
        check_idle_outputs({tag, "/after_release"});
        return;
      end
      if (k == 0) first_px = int'(bus.grayscale_o);
      if (k == NPIX - 1) last_px = int'(bus.grayscale_o);
      if (bus.done_o !== 1'b1 || int'(bus.grayscale_o) != model_mem[k] || bus.busy_o !== 1'b1) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
      if (bus.frame_done_o || bus.timeout_o) early++;
    end
    check({tag, "/stream_bad_pixels"}, 32'(bad), 32'(0));
    if (bad != 0) $display("  %s first bad pixel index %0d", tag, first_bad);
    check({tag, "/last_pixel"}, 32'(last_px), 32'(model_mem[NPIX-1]));
    check({tag, "/no_early_result"}, 32'(early), 32'(0));
    cyc();
    check({tag, "/done_fall"}, 32'(bus.done_o), 32'(0));
    check({tag, "/gray_zero"}, 32'(bus.grayscale_o), 32'(0));
    check({tag, "/busy_wait"}, 32'(bus.busy_o), 32'(1));
    seen = 1'b0;
    for (int c = 1; c <= TIMEOUT + 8 && !seen; c++) begin
      if (ci_delay >= 0 && c == ci_delay + 1) bus.ci_done_i = 1'b1;
      cyc();
      if (bus.frame_done_o || bus.timeout_o) begin
        seen   = 1'b1;
        got_c  = c;
        got_fd = int'(bus.frame_done_o);
        check({tag, "/pulse_exclusive"}, 32'(bus.frame_done_o & bus.timeout_o), 32'(0));
        check({tag, "/busy_falls"}, 32'(bus.busy_o), 32'(0));
      end
    end
    bus.ci_done_i = 1'b0;
    cyc();
    check({tag, "/pulse_one_cycle"}, 32'(bus.frame_done_o | bus.timeout_o), 32'(0));
    check({tag, "/busy_idle"}, 32'(bus.busy_o), 32'(0));
    $display("frame %s: first_px=0x%0h result_cycle=%0d frame_done=%0d", tag, first_px, got_c, got_fd);
  endtask

  task automatic check_result(input string tag, input int ci_delay, input int got_c, input int got_fd);
    check({tag, "/result_cycle"}, 32'(got_c), 32'(model_latency(ci_delay)));
    check({tag, "/result_kind"}, 32'(got_fd), 32'((ci_delay >= 0 && ci_delay < TIMEOUT) ? 1 : 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fp, gc, gf, dly;
    bit st;

    vecs[0] = '{"wr_with_start", 1'b1, 0, 'hAA, 0,  1'b0, 'hAA, 1'b1, 1};
    vecs[1] = '{"other_addr",    1'b1, 5, 'h11, 7,  1'b0, 'hAA, 1'b1, 8};
    vecs[2] = '{"expiry_tie",    1'b1, 0, 'h00, 15, 1'b0, 'h00, 1'b1, 16};
    vecs[3] = '{"timeout",       1'b0, 0, 0,    -1, 1'b0, 'h00, 1'b0, 16};
    vecs[4] = '{"stale_done",    1'b1, 0, 'h5C, 0,  1'b1, 'h5C, 1'b1, 1};

    rst           = 1'b0;
    bus.wr_en_i   = 1'b0;
    bus.wr_addr_i = '0;
    bus.wr_data_i = '0;
    bus.start_i   = 1'b0;
    bus.ci_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_hold");
    rst = 1'b1;
    cyc();
    check_idle_outputs("reset_release");

    // Ramp frame, no result-done: timeout path
    for (int i = 0; i < NPIX; i++) write_px(i, i % 256);
    run_frame("ramp", 1'b0, 0, 0, -1, 1'b0, -1, -1, fp, gc, gf);
    check("ramp/first_px", 32'(fp), 32'(0));
    check_result("ramp", -1, gc, gf);

    // Write and start during STREAM are dropped
    run_frame("busy_ignore", 1'b0, 0, 0, 3, 1'b0, 100, -1, fp, gc, gf);
    check_result("busy_ignore", 3, gc, gf);
    run_frame("after_ignore", 1'b0, 0, 0, 2, 1'b0, -1, -1, fp, gc, gf);
    check("after_ignore/first_px", 32'(fp), 32'(0));
    check_result("after_ignore", 2, gc, gf);

    // Reset at pixel 450, then a full restream
    run_frame("reset_mid", 1'b0, 0, 0, 0, 1'b0, -1, 450, fp, gc, gf);
    run_frame("after_reset", 1'b0, 0, 0, 5, 1'b0, -1, -1, fp, gc, gf);
    check("after_reset/first_px", 32'(fp), 32'(model_mem[0]));
    check_result("after_reset", 5, gc, gf);

    // Table-driven start/result scenarios
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].name, vecs[v].wr_with_start, vecs[v].wa, vecs[v].wd,
                vecs[v].ci_delay, vecs[v].stale, -1, -1, fp, gc, gf);
      check({vecs[v].name, "/first_px"}, 32'(fp), 32'(vecs[v].exp_first));
      check({vecs[v].name, "/result_kind"}, 32'(gf), 32'(vecs[v].exp_fdone));
      check({vecs[v].name, "/result_cycle"}, 32'(gc), 32'(vecs[v].exp_cyc));
    end

    // Randomized frames with scattered writes, some out of range
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 400; w++) begin
        int a, d;
        a = int'($urandom_range(0, 1023));
        d = int'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) write_px(a, d);
        else cyc();
      end
      dly = int'($urandom_range(0, 20));
      st  = 1'($urandom_range(0, 1));
      if (st) dly = 0;
      run_frame($sformatf("random%0d", r), 1'b0, 0, 0, dly, st, -1, -1, fp, gc, gf);
      check($sformatf("random%0d/first_px", r), 32'(fp), 32'(model_mem[0]));
      check_result($sformatf("random%0d", r), dly, gc, gf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ci_frame_streamer.md
Name: ci_frame_streamer

Overview:
- Hardware source for the CI_top pixel stream; replaces the bench-side file reader.
- Holds one ROWS x COLS grayscale frame, loaded through a simple write port.
- On start, drives grayscale/done_i to CI_top in raster order, one pixel per cycle, with done high for exactly ROWS*COLS consecutive cycles.
- Then waits for the CI result-done (done_R8, the last radius) and reports completion or timeout.

Parameters:
- COLS, 30, frame width in pixels
- ROWS, 30, frame height in pixels
- DATA_W, 8, pixel width
- TIMEOUT, 4096, max cycles to wait for ci_done_i after the last pixel
- localparam NPIX = ROWS*COLS; ADDR_W = $clog2(NPIX)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- wr_en_i  in  1  frame-buffer write strobe
- wr_addr_i  in  ADDR_W  raster address, row*COLS+col
- wr_data_i  in  DATA_W  pixel to store
- start_i  in  1  single-cycle request to stream the stored frame
- ci_done_i  in  1  result-done from CI_top (connect done_R8)
- grayscale_o  out  DATA_W  pixel to CI_top grayscale_i
- done_o  out  1  stream-valid to CI_top done_i
- busy_o  out  1  high from start acceptance until return to IDLE
- frame_done_o  out  1  one-cycle pulse when ci_done_i is seen
- timeout_o  out  1  one-cycle pulse when TIMEOUT expires

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - All outputs 0.
  - Pixel counter and timeout counter 0.
  - Buffer contents undefined; the buffer is not cleared.
- Buffer:
  - NPIX x DATA_W single-port-write / synchronous-read array.
  - Writes are accepted only in IDLE with wr_addr_i < NPIX.
  - Writes in other states, or with an out-of-range address, are dropped silently.
- FSM states: IDLE, PREFETCH, STREAM, WAIT_RES.
- IDLE:
  - start_i=1 moves to PREFETCH; busy_o=1 from the next cycle.
  - If wr_en_i and start_i are high in the same cycle, the write lands first; the streamed frame includes it.
- PREFETCH (1 cycle): issues read of addr 0.
- STREAM:
  - Each cycle, grayscale_o = mem[cnt] (registered) and done_o=1. Read of cnt+1 is issued concurrently.
  - cnt runs 0..NPIX-1 with no gaps.
  - After the cycle presenting pixel NPIX-1, done_o=0 and grayscale_o=0; state goes to WAIT_RES.
- Latency:
  - start_i sampled at edge T → first pixel and done_o=1 valid after edge T+2.
  - done_o falls after edge T+2+NPIX.
- WAIT_RES:
  - Timeout counter increments each cycle.
  - ci_done_i=1 → frame_done_o pulse for 1 cycle, then IDLE.
  - Counter reaches TIMEOUT-1 without ci_done_i → timeout_o pulse for 1 cycle, then IDLE.
  - ci_done_i on the same cycle as expiry: frame_done_o wins, no timeout_o.
- busy_o:
  - Falls in the same cycle frame_done_o or timeout_o is asserted; IDLE is entered at the next edge.
  - start_i is ignored while busy_o=1.
- ci_done_i outside WAIT_RES is ignored; a stale level left high from a previous frame is not accepted until WAIT_RES is entered.
- Reset mid-stream:
  - done_o drops asynchronously and the frame is abandoned.
  - After release, a new start restreams from pixel 0.
- Counter widths: cnt is ADDR_W+1 bits, timeout counter is $clog2(TIMEOUT)+1 bits; no wrap-around is possible.

Decomposition:
- Shared package ci_pkg:
  - Frame-size defaults (COLS, ROWS, DATA_W).
  - State encoding for IDLE/PREFETCH/STREAM/WAIT_RES.
  - Clog2-based address-width helper.
- One natural sub-module: ci_frame_ram (parameterised sync-read, sync-write array), so synthesis maps it to block RAM.
- FSM, counters and output registers stay in ci_frame_streamer.

Test Plan:
- Load mem[i] = i%256 for a 30x30 frame, pulse start → done_o high for exactly 900 consecutive cycles starting at T+2; grayscale_o sequence is 0,1,...,255,0,... ending with 899%256=131.
- Integrate with CI_top and load random_matrix data → the CI outputs match the file-driven golden run bit-for-bit; frame_done_o pulses once, the cycle after done_R8 rises.
- Tie ci_done_i=0 with TIMEOUT=16 → timeout_o pulses exactly 16 cycles after done_o falls; busy_o drops with it; frame_done_o never asserts.
- In STREAM, write mem[0]=0xFF and re-pulse start_i → write dropped and start ignored. After completion, a second stream still shows pixel 0 = 0x00 and exactly 900 valid cycles.
- Assert rst=0 at pixel 450 and release after 3 cycles → done_o=0 immediately and all outputs 0. A new start produces a full 900-pixel stream beginning with mem[0].
- Same-cycle wr_en_i (addr 0, data 0xAA) with start_i in IDLE → first streamed pixel is 0xAA.
